sigdelay_ctrl: RTL and testbench
================================

Name: sigdelay_ctrl

Overview:
Sequencing controller for the audio delay line (dual-port RAM plus address counter). It turns a sample-rate strobe into per-sample RAM write and read commands and generates circular write/read addresses for a programmable delay. It tracks buffer fill, so no stale samples reach the output, and manages run-time delay changes with a timed mute. It sits between the sample-clock generator and the RAM, and drives the downstream output stage's valid/mute.

Parameters:
A_WIDTH, 9, RAM address width; delay range 1..2^A_WIDTH-1 samples
DEFAULT_OFFSET, 64, delay (samples) loaded at reset
MUTE_TICKS, 4, samples muted after an in-range delay change (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
en  input  1  run enable
tick  input  1  sample strobe, one-cycle pulse, never on consecutive cycles
offset_in  input  A_WIDTH  requested delay in samples
offset_load  input  1  one-cycle pulse: latch offset_in
wr_en  output  1  RAM write strobe
rd_en  output  1  RAM read strobe
wr_addr  output  A_WIDTH  RAM write address
rd_addr  output  A_WIDTH  RAM read address
offset_cur  output  A_WIDTH  delay currently in force
dout_valid  output  1  RAM dout holds a valid delayed sample this cycle
mute  output  1  downstream must output silence
state  output  2  IDLE=0, FILL=1, RUN=2, RETUNE=3

Behaviour:
- Reset (sync, dominates all inputs, including mid-operation): state=IDLE, wr_addr=0, fill_cnt=0, offset_cur=DEFAULT_OFFSET, mute_cnt=0. Outputs: wr_en=0, rd_en=0, dout_valid=0, mute=1.
- All outputs are registered. fill_cnt is an internal A_WIDTH-bit counter that saturates at 2^A_WIDTH-1.
- Clamp: an offset_in of 0 loads as 1. Equal read/write addresses are never issued.
- rd_addr = (wr_addr - offset_cur) mod 2^A_WIDTH. It is recomputed every cycle and registered with wr_en/rd_en.
- Tick handling: the cycle after tick, wr_en=1 at the current wr_addr. wr_addr then increments once, wrapping 2^A_WIDTH-1 to 0.
- In RUN and RETUNE, rd_en=1 in the same cycle as wr_en. It is 0 in IDLE and FILL.
- RAM read latency is 1 cycle. dout_valid=1 the cycle after rd_en, only when rd_en was issued in RUN.
- mute=1 in IDLE, FILL and RETUNE, and 0 in RUN. mute is registered from the state.
- IDLE:
  - Ticks are ignored and no strobes are issued.
  - On en=1, clear fill_cnt and go to FILL. wr_addr holds its value.
- FILL:
  - Each tick writes and increments fill_cnt.
  - When fill_cnt reaches offset_cur, go to RUN. The first read is issued on the next tick.
- RUN: each tick writes and reads.
- RETUNE:
  - Behaves as RUN, but mute=1 and dout_valid=0.
  - mute_cnt is loaded with MUTE_TICKS on entry and decrements per tick. At 0, go to RUN.
- offset_load, in any state other than IDLE:
  - offset_cur takes the clamped offset_in on the next cycle.
  - In FILL, or if the new offset > fill_cnt: go to (or stay in) FILL.
  - Otherwise: go to RETUNE and reload mute_cnt.
  - A load during RETUNE restarts the mute.
- offset_load in IDLE: offset_cur is updated and the state does not change.
- tick and offset_load in the same cycle: the tick is processed with the old offset_cur. The new offset applies from the next tick.
- en=0 in any state: go to IDLE next cycle.
  - A tick in that same cycle is dropped.
  - fill_cnt is cleared on the next en=1, so the buffer is refilled.

Test Plan:
- Reset, offset 4: apply en=1, then 6 ticks. Required: state FILL for ticks 1-4 and RUN at tick 5. The first rd_en is at tick 5 with wr_addr=4, rd_addr=0. dout_valid pulses 1 cycle after the tick-5 rd_en, and mute deasserts on entering RUN.
- Wrap: with offset 4 in RUN, run until wr_addr=2. Required: rd_addr=510 (A_WIDTH=9); wr_addr goes 511 then 0 with no glitch on dout_valid.
- Shrink delay in RUN (fill saturated), load offset 2 with MUTE_TICKS=4. Required: RETUNE with mute=1 and no dout_valid for 4 ticks. Reads continue with rd_addr=wr_addr-2. RUN resumes on the 5th tick.
- Grow delay: after 10 ticks at offset 4, load 20. Required: state FILL, no rd_en, and RUN is reached after fill_cnt=20.
- Edge cases:
  - Loading offset 0 gives offset_cur=1.
  - tick and offset_load in the same cycle: that tick's rd_addr uses the old offset.
  - Load during RETUNE restarts the 4-tick mute.
- Control interruptions:
  - en drop in RUN: IDLE next cycle, no strobes; re-enable forces a FILL of offset_cur ticks.
  - rst mid-RUN: all outputs at reset values next cycle and offset_cur=64.

Source files
------------

// File: rtl/sigdelay_if.sv
// sigdelay_if: control inputs and RAM-command/status outputs of the delay-line sequencer.
interface sigdelay_if #(parameter int A_WIDTH = 9);
    logic               en;
    logic               tick;
    logic [A_WIDTH-1:0] offset_in;
    logic               offset_load;
    logic               wr_en;
    logic               rd_en;
    logic [A_WIDTH-1:0] wr_addr;
    logic [A_WIDTH-1:0] rd_addr;
    logic [A_WIDTH-1:0] offset_cur;
    logic               dout_valid;
    logic               mute;
    logic [1:0]         state;

    modport master (
        output en, tick, offset_in, offset_load,
        input  wr_en, rd_en, wr_addr, rd_addr, offset_cur, dout_valid, mute, state
    );
    modport slave (
        input  en, tick, offset_in, offset_load,
        output wr_en, rd_en, wr_addr, rd_addr, offset_cur, dout_valid, mute, state
    );
endinterface

// File: rtl/sigdelay_ctrl.sv
// sigdelay_ctrl: turns sample ticks into circular RAM write/read commands for a
// programmable delay, tracking buffer fill and muting across delay changes.
module sigdelay_ctrl #(
    parameter int A_WIDTH        = 9,
    parameter int DEFAULT_OFFSET = 64,
    parameter int MUTE_TICKS     = 4
) (
    input  logic      clk,
    input  logic      rst,
    sigdelay_if.slave bus
);
    localparam int M_W = $clog2(MUTE_TICKS + 1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, RETUNE} state_t;

    state_t             st, st_nxt;
    logic [A_WIDTH-1:0] wr_addr, rd_addr, offset_cur, fill_cnt, fill_nxt, wr_nxt, off_new;
    logic [M_W-1:0]     mute_cnt, mute_nxt;
    logic               wr_en, rd_en, rd_run, dout_valid, mute, tk;

    always_comb begin
        tk       = bus.tick && bus.en && st != IDLE;
        off_new  = bus.offset_in == '0 ? A_WIDTH'(1) : bus.offset_in;
        wr_nxt   = wr_en ? wr_addr + A_WIDTH'(1) : wr_addr;
        fill_nxt = st == IDLE ? (bus.en ? '0 : fill_cnt)
                 : (tk && fill_cnt != '1 ? fill_cnt + A_WIDTH'(1) : fill_cnt);
        mute_nxt = tk && mute_cnt != '0 ? mute_cnt - M_W'(1) : mute_cnt;
        st_nxt   = st;
        if (!bus.en)
            st_nxt = IDLE;
        else if (st == IDLE)
            st_nxt = FILL;
        else if (bus.offset_load) begin
            // compare against the fill level after any same-cycle tick
            st_nxt   = (st == FILL || off_new > fill_nxt) ? FILL : RETUNE;
            mute_nxt = st_nxt == RETUNE ? M_W'(MUTE_TICKS) : mute_nxt;
        end
        else if (st == FILL && fill_cnt >= offset_cur)
            st_nxt = RUN;
        else if (st == RETUNE && mute_nxt == '0)
            st_nxt = RUN;
    end

    always_ff @(posedge clk)
        st <= rst ? IDLE : st_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            fill_cnt   <= '0;
            offset_cur <= A_WIDTH'(DEFAULT_OFFSET);
            mute_cnt   <= '0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            rd_run     <= 1'b0;
            dout_valid <= 1'b0;
            mute       <= 1'b1;
        end else begin
            wr_addr    <= wr_nxt;
            rd_addr    <= wr_nxt - offset_cur;
            fill_cnt   <= fill_nxt;
            offset_cur <= bus.offset_load ? off_new : offset_cur;
            mute_cnt   <= mute_nxt;
            wr_en      <= tk;
            rd_en      <= tk && (st == RUN || st == RETUNE);
            rd_run     <= tk && st == RUN;
            dout_valid <= rd_run;
            mute       <= st_nxt != RUN;
        end
    end

    assign bus.wr_en      = wr_en;
    assign bus.rd_en      = rd_en;
    assign bus.wr_addr    = wr_addr;
    assign bus.rd_addr    = rd_addr;
    assign bus.offset_cur = offset_cur;
    assign bus.dout_valid = dout_valid;
    assign bus.mute       = mute;
    assign bus.state      = st;
endmodule

// File: tb/tb_sigdelay_ctrl.sv
// tb_sigdelay_ctrl: directed scenarios for sigdelay_ctrl with A_WIDTH=9,
// DEFAULT_OFFSET=64, MUTE_TICKS=4; inputs change on negedge, outputs sampled on negedge.
module tb_sigdelay_ctrl;
    localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_RUN = 2'd2, S_RETUNE = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] st0, s_st;
    logic       s_wr, s_rd, s_dv, s_mute;
    logic [8:0] s_wa, s_ra;

    sigdelay_if #(.A_WIDTH(9)) bus ();
    sigdelay_ctrl #(.A_WIDTH(9), .DEFAULT_OFFSET(64), .MUTE_TICKS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    // strobe cycle sampled after the first edge, dout_valid/state after the second
    task automatic pulse_tick(input logic load, input logic [8:0] val);
        st0 = bus.state;
        bus.tick = 1'b1; bus.offset_load = load; bus.offset_in = val;
        @(negedge clk);
        bus.tick = 1'b0; bus.offset_load = 1'b0;
        s_wr = bus.wr_en; s_rd = bus.rd_en; s_wa = bus.wr_addr; s_ra = bus.rd_addr;
        @(negedge clk);
        s_dv = bus.dout_valid; s_mute = bus.mute; s_st = bus.state;
    endtask

    task automatic load_offset(input logic [8:0] val);
        bus.offset_load = 1'b1; bus.offset_in = val;
        @(negedge clk);
        bus.offset_load = 1'b0;
    endtask

    task automatic test_reset();
        bus.en = 1'b0; bus.tick = 1'b0; bus.offset_load = 1'b0; bus.offset_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state, S_IDLE); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", bus.wr_en); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", bus.rd_en); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %0b expected 0", bus.dout_valid); end
        checks++; if (bus.mute !== 1'b1) begin errors++; $display("FAIL reset_mute: got %0b expected 1", bus.mute); end
        checks++; if (bus.wr_addr !== 9'd0) begin errors++; $display("FAIL reset_wr_addr: got %0d expected 0", bus.wr_addr); end
        checks++; if (bus.offset_cur !== 9'd64) begin errors++; $display("FAIL reset_offset: got %0d expected 64", bus.offset_cur); end
    endtask

    task automatic test_fill();
        logic [1:0] e;
        load_offset(9'd4);
        checks++; if (bus.offset_cur !== 9'd4) begin errors++; $display("FAIL idle_load_offset: got %0d expected 4", bus.offset_cur); end
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL idle_load_state: got %0d expected %0d", bus.state, S_IDLE); end
        bus.en = 1'b1;
        @(negedge clk);
        checks++; if (bus.state !== S_FILL) begin errors++; $display("FAIL enable_state: got %0d expected %0d", bus.state, S_FILL); end
        for (int i = 1; i <= 6; i++) begin
            pulse_tick(1'b0, 9'd0);
            e = i <= 4 ? S_FILL : S_RUN;
            checks++; if (st0 !== e) begin errors++; $display("FAIL fill_state tick %0d: got %0d expected %0d", i, st0, e); end
            checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL fill_wr_en tick %0d: got %0b expected 1", i, s_wr); end
            checks++; if (s_rd !== (i >= 5)) begin errors++; $display("FAIL fill_rd_en tick %0d: got %0b expected %0b", i, s_rd, i >= 5); end
            checks++; if (s_wa !== 9'(i - 1)) begin errors++; $display("FAIL fill_wr_addr tick %0d: got %0d expected %0d", i, s_wa, i - 1); end
            checks++; if (s_dv !== (i >= 5)) begin errors++; $display("FAIL fill_dout_valid tick %0d: got %0b expected %0b", i, s_dv, i >= 5); end
            checks++; if (s_mute !== (i < 4)) begin errors++; $display("FAIL fill_mute tick %0d: got %0b expected %0b", i, s_mute, i < 4); end
            if (i == 5) begin
                checks++; if (s_ra !== 9'd0) begin errors++; $display("FAIL first_rd_addr: got %0d expected 0", s_ra); end
            end
        end
    endtask

    task automatic test_wrap();
        logic [8:0] exp_wa;
        exp_wa = 9'd6;
        for (int i = 0; i < 509; i++) begin
            pulse_tick(1'b0, 9'd0);
            checks++; if (s_wa !== exp_wa) begin errors++; $display("FAIL wrap_wr_addr: got %0d expected %0d", s_wa, exp_wa); end
            checks++; if (s_ra !== 9'(exp_wa - 9'd4)) begin errors++; $display("FAIL wrap_rd_addr: got %0d expected %0d", s_ra, 9'(exp_wa - 9'd4)); end
            checks++; if (s_dv !== 1'b1) begin errors++; $display("FAIL wrap_dout_valid at wr_addr %0d: got %0b expected 1", s_wa, s_dv); end
            exp_wa = exp_wa + 9'd1;
        end
        checks++; if (s_wa !== 9'd2) begin errors++; $display("FAIL wrap_end_wr_addr: got %0d expected 2", s_wa); end
        checks++; if (s_ra !== 9'd510) begin errors++; $display("FAIL wrap_end_rd_addr: got %0d expected 510", s_ra); end
    endtask

    task automatic test_shrink();
        logic [1:0] e;
        load_offset(9'd2);
        checks++; if (bus.offset_cur !== 9'd2) begin errors++; $display("FAIL shrink_offset: got %0d expected 2", bus.offset_cur); end
        checks++; if (bus.state !== S_RETUNE) begin errors++; $display("FAIL shrink_state: got %0d expected %0d", bus.state, S_RETUNE); end
        checks++; if (bus.mute !== 1'b1) begin errors++; $display("FAIL shrink_mute: got %0b expected 1", bus.mute); end
        for (int i = 1; i <= 5; i++) begin
            pulse_tick(1'b0, 9'd0);
            e = i <= 4 ? S_RETUNE : S_RUN;
            checks++; if (st0 !== e) begin errors++; $display("FAIL shrink_tick_state %0d: got %0d expected %0d", i, st0, e); end
            checks++; if (s_rd !== 1'b1) begin errors++; $display("FAIL shrink_rd_en %0d: got %0b expected 1", i, s_rd); end
            checks++; if (s_ra !== 9'(s_wa - 9'd2)) begin errors++; $display("FAIL shrink_rd_addr %0d: got %0d expected %0d", i, s_ra, 9'(s_wa - 9'd2)); end
            checks++; if (s_dv !== (i == 5)) begin errors++; $display("FAIL shrink_dout_valid %0d: got %0b expected %0b", i, s_dv, i == 5); end
        end
    endtask

    task automatic test_en_drop();
        logic [1:0] e;
        bus.en = 1'b0; bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL endrop_state: got %0d expected %0d", bus.state, S_IDLE); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL endrop_wr_en: got %0b expected 0", bus.wr_en); end
        checks++; if (bus.mute !== 1'b1) begin errors++; $display("FAIL endrop_mute: got %0b expected 1", bus.mute); end
        pulse_tick(1'b0, 9'd0);
        checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL idle_tick_wr_en: got %0b expected 0", s_wr); end
        bus.en = 1'b1;
        @(negedge clk);
        checks++; if (bus.state !== S_FILL) begin errors++; $display("FAIL reenable_state: got %0d expected %0d", bus.state, S_FILL); end
        for (int i = 1; i <= 3; i++) begin
            pulse_tick(1'b0, 9'd0);
            e = i <= 2 ? S_FILL : S_RUN;
            checks++; if (st0 !== e) begin errors++; $display("FAIL refill_state %0d: got %0d expected %0d", i, st0, e); end
            checks++; if (s_rd !== (i == 3)) begin errors++; $display("FAIL refill_rd_en %0d: got %0b expected %0b", i, s_rd, i == 3); end
            checks++; if (s_dv !== (i == 3)) begin errors++; $display("FAIL refill_dout_valid %0d: got %0b expected %0b", i, s_dv, i == 3); end
        end
    endtask

    task automatic test_grow();
        logic [1:0] e;
        bus.en = 1'b0;
        @(negedge clk);
        load_offset(9'd4);
        bus.en = 1'b1;
        @(negedge clk);
        repeat (10) pulse_tick(1'b0, 9'd0);
        checks++; if (s_st !== S_RUN) begin errors++; $display("FAIL grow_pre_state: got %0d expected %0d", s_st, S_RUN); end
        load_offset(9'd20);
        checks++; if (bus.state !== S_FILL) begin errors++; $display("FAIL grow_state: got %0d expected %0d", bus.state, S_FILL); end
        checks++; if (bus.offset_cur !== 9'd20) begin errors++; $display("FAIL grow_offset: got %0d expected 20", bus.offset_cur); end
        for (int i = 11; i <= 21; i++) begin
            pulse_tick(1'b0, 9'd0);
            e = i <= 20 ? S_FILL : S_RUN;
            checks++; if (st0 !== e) begin errors++; $display("FAIL grow_tick_state %0d: got %0d expected %0d", i, st0, e); end
            checks++; if (s_wr !== 1'b1) begin errors++; $display("FAIL grow_wr_en %0d: got %0b expected 1", i, s_wr); end
            checks++; if (s_rd !== (i == 21)) begin errors++; $display("FAIL grow_rd_en %0d: got %0b expected %0b", i, s_rd, i == 21); end
        end
    endtask

    task automatic test_clamp_retune();
        logic [1:0] e;
        load_offset(9'd0);
        checks++; if (bus.offset_cur !== 9'd1) begin errors++; $display("FAIL clamp_offset: got %0d expected 1", bus.offset_cur); end
        checks++; if (bus.state !== S_RETUNE) begin errors++; $display("FAIL clamp_state: got %0d expected %0d", bus.state, S_RETUNE); end
        for (int i = 1; i <= 2; i++) begin
            pulse_tick(1'b0, 9'd0);
            checks++; if (st0 !== S_RETUNE) begin errors++; $display("FAIL clamp_tick_state %0d: got %0d expected %0d", i, st0, S_RETUNE); end
            checks++; if (s_ra !== 9'(s_wa - 9'd1)) begin errors++; $display("FAIL clamp_rd_addr %0d: got %0d expected %0d", i, s_ra, 9'(s_wa - 9'd1)); end
        end
        pulse_tick(1'b1, 9'd5);
        checks++; if (s_ra !== 9'(s_wa - 9'd1)) begin errors++; $display("FAIL same_cycle_rd_addr: got %0d expected %0d", s_ra, 9'(s_wa - 9'd1)); end
        checks++; if (bus.offset_cur !== 9'd5) begin errors++; $display("FAIL same_cycle_offset: got %0d expected 5", bus.offset_cur); end
        for (int k = 1; k <= 5; k++) begin
            pulse_tick(1'b0, 9'd0);
            e = k <= 4 ? S_RETUNE : S_RUN;
            checks++; if (st0 !== e) begin errors++; $display("FAIL restart_state %0d: got %0d expected %0d", k, st0, e); end
            checks++; if (s_ra !== 9'(s_wa - 9'd5)) begin errors++; $display("FAIL restart_rd_addr %0d: got %0d expected %0d", k, s_ra, 9'(s_wa - 9'd5)); end
            checks++; if (s_dv !== (k == 5)) begin errors++; $display("FAIL restart_dout_valid %0d: got %0b expected %0b", k, s_dv, k == 5); end
        end
    endtask

    task automatic test_rst_mid();
        bus.tick = 1'b1; rst = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", bus.state, S_IDLE); end
        checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL midrst_wr_en: got %0b expected 0", bus.wr_en); end
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("FAIL midrst_rd_en: got %0b expected 0", bus.rd_en); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL midrst_dout_valid: got %0b expected 0", bus.dout_valid); end
        checks++; if (bus.mute !== 1'b1) begin errors++; $display("FAIL midrst_mute: got %0b expected 1", bus.mute); end
        checks++; if (bus.wr_addr !== 9'd0) begin errors++; $display("FAIL midrst_wr_addr: got %0d expected 0", bus.wr_addr); end
        checks++; if (bus.offset_cur !== 9'd64) begin errors++; $display("FAIL midrst_offset: got %0d expected 64", bus.offset_cur); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_wrap();
        test_shrink();
        test_en_drop();
        test_grow();
        test_clamp_retune();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
